countdown_timer_bcd: RTL

- Downstream consumer of the mod-8 counter's F output.
- Counts rising edges of F as timing strobes and runs a preloadable MM:SS countdown in packed BCD.
- Start/pause/load controls feed a 4-state FSM.
- Flags expiry with a one-cycle done pulse and a sticky expired level, for the display/alarm stage.

---
 rtl/countdown_timer_bcd.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
// Counts rising edges of the tick strobe (the F output of the mod-8 counter)
// and runs a preloadable MM:SS countdown held in packed BCD. A four-state
// FSM (IDLE, RUN, PAUSE, DONE) is driven by the load/start/pause controls.
// Expiry is reported as a one-cycle done pulse plus a sticky expired level.
//
// Ports:
//   clock    - system clock, all state changes on its rising edge
//   clearn   - asynchronous active-low reset
//   tick     - count strobe, only rising edges are counted
//   load     - load min_in/sec_in (ignored while running)
//   start    - begin or resume the countdown
//   pause    - suspend the countdown
//   min_in   - preset minutes, packed BCD 00..59
//   sec_in   - preset seconds, packed BCD 00..59
//   min_out  - current minutes, packed BCD
//   sec_out  - current seconds, packed BCD
//   running  - high while in RUN
//   done     - one-cycle pulse on entry to DONE
//   expired  - high while in DONE
//   load_err - one-cycle pulse when a load is rejected for invalid BCD
module countdown_timer_bcd #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic       clock,
   input  logic       clearn,
   input  logic       tick,
   input  logic       load,
   input  logic       start,
   input  logic       pause,
   input  logic [7:0] min_in,
   input  logic [7:0] sec_in,
   output logic [7:0] min_out,
   output logic [7:0] sec_out,
   output logic       running,
   output logic       done,
   output logic       expired,
   output logic       load_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Prescaler value at which the next counted edge triggers a decrement.
   localparam logic [7:0] PRESCALE_LAST = 8'(PRESCALE - 1);

   state_t     state_q, state_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic [7:0] prescale_q, prescale_d;
   logic       tick_q;
   logic       running_q, running_d;
   logic       done_q, done_d;
   logic       expired_q, expired_d;
   logic       loadErr_q, loadErr_d;

   logic        tickEdge;
   logic        presetValid;
   logic [15:0] decremented;

   // A packed BCD byte is a legal minutes/seconds value when the units
   // digit is at most 9 and the tens digit is at most 5.
   function automatic logic bcdTimeValid(input logic [7:0] v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd5);
   endfunction

   // One-second BCD decrement of {minutes, seconds}. Each digit that is
   // already zero wraps to its maximum and borrows from the next digit up.
   // Only used while the time is non-zero, so the minutes tens digit never
   // has to borrow from anything.
   function automatic logic [15:0] bcdDecrement(input logic [15:0] t);
      logic [3:0] mt, mu, st, su;
      {mt, mu, st, su} = t;
      if (su != 4'd0) begin
         su = su - 4'd1;
      end else begin
         su = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mu != 4'd0) begin
               mu = mu - 4'd1;
            end else begin
               mu = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mu, st, su};
   endfunction

   // Rising-edge detect on tick. Because tick_q clears on reset, a tick
   // that is already high on the first clock after reset counts as an edge.
   assign tickEdge    = tick & ~tick_q;
   assign presetValid = bcdTimeValid(min_in) && bcdTimeValid(sec_in);
   assign decremented = bcdDecrement({min_q, sec_q});

   // Next-state logic. Controls are taken in priority order load, start,
   // pause, and only one acts per cycle. A load in RUN is simply ignored,
   // so it does not block a pause or the count in that cycle. Counting
   // only happens in RUN when no pause is requested, so an edge that
   // coincides with a pause is dropped.
   always_comb begin
      state_d    = state_q;
      min_d      = min_q;
      sec_d      = sec_q;
      prescale_d = prescale_q;
      done_d     = 1'b0;
      loadErr_d  = 1'b0;

      if (load && (state_q != RUN)) begin
         if (presetValid) begin
            min_d      = min_in;
            sec_d      = sec_in;
            prescale_d = 8'd0;
            state_d    = IDLE;
         end else begin
            loadErr_d = 1'b1;
         end
      end else if (start && ((state_q == IDLE) || (state_q == PAUSE))) begin
         if ((min_q == 8'h00) && (sec_q == 8'h00)) begin
            state_d = DONE;
            done_d  = 1'b1;
         end else begin
            state_d = RUN;
         end
      end else if (pause && (state_q == RUN)) begin
         state_d = PAUSE;
      end else if ((state_q == RUN) && tickEdge) begin
         if (prescale_q == PRESCALE_LAST) begin
            prescale_d     = 8'd0;
            {min_d, sec_d} = decremented;
            if (decremented == 16'h0000) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end else begin
            prescale_d = prescale_q + 8'd1;
         end
      end

      running_d = (state_d == RUN);
      expired_d = (state_d == DONE);
   end

   // All state, including the decoded status outputs, is registered here so
   // that running/expired come straight from flops and cannot glitch.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_q    <= IDLE;
         min_q      <= 8'h00;
         sec_q      <= 8'h00;
         prescale_q <= 8'd0;
         tick_q     <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         expired_q  <= 1'b0;
         loadErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         min_q      <= min_d;
         sec_q      <= sec_d;
         prescale_q <= prescale_d;
         tick_q     <= tick;
         running_q  <= running_d;
         done_q     <= done_d;
         expired_q  <= expired_d;
         loadErr_q  <= loadErr_d;
      end
   end

   assign min_out  = min_q;
   assign sec_out  = sec_q;
   assign running  = running_q;
   assign done     = done_q;
   assign expired  = expired_q;
   assign load_err = loadErr_q;

endmodule
